// File: rtl/ofdm_tx_encoder.sv
// OFDM transmit bit pipeline: service/data/tail/pad sequencing, 802.11 scrambler,
// K=7 convolutional encoder with puncturing and an out_ready-paced serial output.
module ofdm_tx_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [7:0]  rate,
    input  logic        do_scramble,
    input  logic [6:0]  scramble_seed,
    input  logic [15:0] num_bits,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    output logic        byte_in_ready,
    output logic        coded_out,
    output logic        coded_out_strobe,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_SERVICE, S_DATA, S_TAIL, S_PAD, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        scr_en_q, scr_en_d;
    logic [7:0]  ndbps_q, ndbps_d;
    logic [1:0]  punc_q, punc_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] nbits_q, nbits_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  sym_q, sym_d;
    logic [6:0]  scr_q, scr_d;
    logic [5:0]  hist_q, hist_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [13:0] bytes_left_q, bytes_left_d;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  pcnt_q, pcnt_d;
    logic        coded_q, coded_d;
    logic        strobe_q, strobe_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        feed_s, use_scr_s, fb_s, raw_s, bit_s, a_s, b_s;
    logic        keep_a_s, keep_b_s, sym_wrap_s;
    logic [16:0] nbytes_s;
    logic        unused_s;

    assign unused_s = ^rate[7:4];

    function automatic logic [7:0] ndbps_of(input logic [3:0] code);
        case (code)
            4'b1011: ndbps_of = 8'd24;
            4'b1111: ndbps_of = 8'd36;
            4'b1010: ndbps_of = 8'd48;
            4'b1110: ndbps_of = 8'd72;
            4'b1001: ndbps_of = 8'd96;
            4'b1101: ndbps_of = 8'd144;
            4'b1000: ndbps_of = 8'd192;
            4'b1100: ndbps_of = 8'd216;
            default: ndbps_of = 8'd24;
        endcase
    endfunction

    // 0: rate 1/2, 1: rate 2/3, 2: rate 3/4
    function automatic logic [1:0] punc_of(input logic [3:0] code);
        case (code)
            4'b1011, 4'b1010, 4'b1001: punc_of = 2'd0;
            4'b1000:                   punc_of = 2'd1;
            4'b1111, 4'b1110, 4'b1101, 4'b1100: punc_of = 2'd2;
            default:                   punc_of = 2'd0;
        endcase
    endfunction

    function automatic logic conv_a(input logic b, input logic [5:0] d);
        conv_a = b ^ d[1] ^ d[2] ^ d[4] ^ d[5];
    endfunction

    function automatic logic conv_b(input logic b, input logic [5:0] d);
        conv_b = b ^ d[0] ^ d[1] ^ d[2] ^ d[5];
    endfunction

    // Next-state logic: output emission, byte fetch, bit feed and frame sequencing.
    always_comb begin
        state_d      = state_q;
        scr_en_d     = scr_en_q;
        ndbps_d      = ndbps_q;
        punc_d       = punc_q;
        phase_d      = phase_q;
        nbits_d      = nbits_q;
        cnt_d        = cnt_q;
        sym_d        = sym_q;
        scr_d        = scr_q;
        hist_d       = hist_q;
        hold_d       = hold_q;
        hold_cnt_d   = hold_cnt_q;
        bytes_left_d = bytes_left_q;
        pend_d       = pend_q;
        pcnt_d       = pcnt_q;
        coded_d      = coded_q;
        strobe_d     = 1'b0;
        done_d       = 1'b0;
        nbytes_s     = {1'b0, num_bits} + 17'd7;

        // A new input bit may enter only when the pending buffer drains this cycle.
        if (!enable || !out_ready || pcnt_q == 2'd2) begin
            feed_s = 1'b0;
        end else if (state_q == S_SERVICE || state_q == S_TAIL || state_q == S_PAD) begin
            feed_s = 1'b1;
        end else if (state_q == S_DATA) begin
            feed_s = (hold_cnt_q != 4'd0);
        end else begin
            feed_s = 1'b0;
        end

        raw_s      = (state_q == S_DATA) ? hold_q[0] : 1'b0;
        use_scr_s  = scr_en_q && (state_q != S_TAIL);
        fb_s       = scr_q[6] ^ scr_q[3];
        bit_s      = raw_s ^ (use_scr_s & fb_s);
        a_s        = conv_a(bit_s, hist_q);
        b_s        = conv_b(bit_s, hist_q);
        sym_wrap_s = (sym_q == ndbps_q - 8'd1);

        case (punc_q)
            2'd1: begin
                keep_a_s = 1'b1;
                keep_b_s = (phase_q == 2'd0);
            end
            2'd2: begin
                keep_a_s = (phase_q != 2'd2);
                keep_b_s = (phase_q != 2'd1);
            end
            default: begin
                keep_a_s = 1'b1;
                keep_b_s = 1'b1;
            end
        endcase

        if (enable && out_ready && pcnt_q != 2'd0) begin
            coded_d  = pend_q[0];
            strobe_d = 1'b1;
            pend_d   = {1'b0, pend_q[1]};
            pcnt_d   = pcnt_q - 2'd1;
        end else begin
            strobe_d = 1'b0;
        end

        if (enable && byte_in_valid && ready_q) begin
            hold_d       = byte_in;
            hold_cnt_d   = 4'd8;
            bytes_left_d = bytes_left_q - 14'd1;
        end else begin
            bytes_left_d = bytes_left_q;
        end

        if (feed_s) begin
            if (use_scr_s) begin
                scr_d = {scr_q[5:0], fb_s};
            end else begin
                scr_d = scr_q;
            end
            hist_d = {hist_q[4:0], bit_s};
            sym_d  = sym_wrap_s ? 8'd0 : sym_q + 8'd1;
            if (keep_a_s && keep_b_s) begin
                pend_d = {b_s, a_s};
                pcnt_d = 2'd2;
            end else if (keep_a_s) begin
                pend_d = {1'b0, a_s};
                pcnt_d = 2'd1;
            end else begin
                pend_d = {1'b0, b_s};
                pcnt_d = 2'd1;
            end
            case (punc_q)
                2'd1:    phase_d = {1'b0, ~phase_q[0]};
                2'd2:    phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                default: phase_d = 2'd0;
            endcase
        end else begin
            hist_d = hist_q;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && start) begin
                    scr_en_d     = do_scramble;
                    ndbps_d      = ndbps_of(rate[3:0]);
                    punc_d       = punc_of(rate[3:0]);
                    nbits_d      = num_bits;
                    scr_d        = (scramble_seed == 7'd0) ? 7'h7F : scramble_seed;
                    phase_d      = 2'd0;
                    cnt_d        = 16'd0;
                    sym_d        = 8'd0;
                    hist_d       = 6'd0;
                    hold_d       = 8'd0;
                    hold_cnt_d   = 4'd0;
                    bytes_left_d = nbytes_s[16:3];
                    if (do_scramble) begin
                        state_d = S_SERVICE;
                    end else if (num_bits != 16'd0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_TAIL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (feed_s && cnt_q == 16'd15) begin
                    cnt_d   = 16'd0;
                    state_d = (nbits_q != 16'd0) ? S_DATA : S_TAIL;
                end else if (feed_s) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DATA: begin
                if (feed_s && cnt_q == nbits_q - 16'd1) begin
                    cnt_d      = 16'd0;
                    hold_d     = 8'd0;
                    hold_cnt_d = 4'd0;
                    state_d    = S_TAIL;
                end else if (feed_s) begin
                    cnt_d      = cnt_q + 16'd1;
                    hold_d     = {1'b0, hold_q[7:1]};
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_TAIL: begin
                if (feed_s && cnt_q == 16'd5) begin
                    cnt_d   = 16'd0;
                    state_d = sym_wrap_s ? S_DONE : S_PAD;
                end else if (feed_s) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_PAD: begin
                if (feed_s && sym_wrap_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_DONE: begin
                if (enable && pcnt_q == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_DATA) && (hold_cnt_d == 4'd0) && (bytes_left_d != 14'd0);
        busy_d  = (state_d != S_IDLE);
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            scr_en_q     <= 1'b0;
            ndbps_q      <= 8'd0;
            punc_q       <= 2'd0;
            phase_q      <= 2'd0;
            nbits_q      <= 16'd0;
            cnt_q        <= 16'd0;
            sym_q        <= 8'd0;
            scr_q        <= 7'd0;
            hist_q       <= 6'd0;
            hold_q       <= 8'd0;
            hold_cnt_q   <= 4'd0;
            bytes_left_q <= 14'd0;
            pend_q       <= 2'd0;
            pcnt_q       <= 2'd0;
            coded_q      <= 1'b0;
            strobe_q     <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scr_en_q     <= scr_en_d;
            ndbps_q      <= ndbps_d;
            punc_q       <= punc_d;
            phase_q      <= phase_d;
            nbits_q      <= nbits_d;
            cnt_q        <= cnt_d;
            sym_q        <= sym_d;
            scr_q        <= scr_d;
            hist_q       <= hist_d;
            hold_q       <= hold_d;
            hold_cnt_q   <= hold_cnt_d;
            bytes_left_q <= bytes_left_d;
            pend_q       <= pend_d;
            pcnt_q       <= pcnt_d;
            coded_q      <= coded_d;
            strobe_q     <= strobe_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_in_ready    = ready_q;
    assign coded_out        = coded_q;
    assign coded_out_strobe = strobe_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_ofdm_tx_encoder.sv
// Self-checking bench for ofdm_tx_encoder: frame vector table against a bit-list
// reference model, plus impulse, scrambler and mid-frame reset sequences.
module tb_ofdm_tx_encoder;

    typedef bit bq_t[$];
    typedef struct {
        logic [3:0] rcode;
        bit         scr;
        logic [6:0] seed;
        int         nb;
        bit         bp;
        int         exp_strobes;
        int         byte0;
    } vec_t;

    localparam logic [6:0] G133 = 7'o133;
    localparam logic [6:0] G171 = 7'o171;

    logic        clock = 1'b0;
    logic        reset, enable, start;
    logic [7:0]  rate;
    logic        do_scramble;
    logic [6:0]  scramble_seed;
    logic [15:0] num_bits;
    logic [7:0]  byte_in;
    logic        byte_in_valid, byte_in_ready;
    logic        coded_out, coded_out_strobe, out_ready, busy, done;

    int          n_checks = 0;
    int          n_fail = 0;
    bq_t         got, expq, got_keep;
    logic [7:0]  data[$];
    logic [7:0]  data_keep[$];
    vec_t        tbl[13];

    ofdm_tx_encoder dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .rate(rate), .do_scramble(do_scramble), .scramble_seed(scramble_seed),
        .num_bits(num_bits), .byte_in(byte_in), .byte_in_valid(byte_in_valid),
        .byte_in_ready(byte_in_ready), .coded_out(coded_out),
        .coded_out_strobe(coded_out_strobe), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ndbps_of(input logic [3:0] c);
        case (c)
            4'b1011: return 24;
            4'b1111: return 36;
            4'b1010: return 48;
            4'b1110: return 72;
            4'b1001: return 96;
            4'b1101: return 144;
            4'b1000: return 192;
            default: return 216;
        endcase
    endfunction

    function automatic int kind_of(input logic [3:0] c);
        if (c == 4'b1011 || c == 4'b1010 || c == 4'b1001) return 0;
        if (c == 4'b1000) return 1;
        return 2;
    endfunction

    // Convolutional code from the octal generators, then punctured by position.
    function automatic bq_t encode(input bq_t src, input int kind);
        bq_t dst;
        bit a, b, p, ka, kb;
        for (int i = 0; i < src.size(); i++) begin
            a = 1'b0;
            b = 1'b0;
            for (int k = 0; k < 7; k++) begin
                p = (i >= k) ? src[i - k] : 1'b0;
                if (G133[6 - k]) a ^= p;
                if (G171[6 - k]) b ^= p;
            end
            ka = 1'b1;
            kb = 1'b1;
            if (kind == 1 && (i % 2) == 1) kb = 1'b0;
            if (kind == 2 && (i % 3) == 1) kb = 1'b0;
            if (kind == 2 && (i % 3) == 2) ka = 1'b0;
            if (ka) dst.push_back(a);
            if (kb) dst.push_back(b);
        end
        return dst;
    endfunction

    task automatic build_model(input logic [3:0] rc, input bit scr, input logic [6:0] seed, input int nb);
        bq_t raw, fl, inb;
        logic [6:0] s;
        bit fb;
        int n = ndbps_of(rc);
        if (scr) for (int i = 0; i < 16; i++) begin raw.push_back(1'b0); fl.push_back(1'b1); end
        for (int i = 0; i < nb; i++) begin raw.push_back(data[i / 8][i % 8]); fl.push_back(scr); end
        for (int i = 0; i < 6; i++) begin raw.push_back(1'b0); fl.push_back(1'b0); end
        while (raw.size() % n != 0) begin raw.push_back(1'b0); fl.push_back(scr); end
        s = (seed == 7'd0) ? 7'h7F : seed;
        for (int i = 0; i < raw.size(); i++) begin
            if (fl[i]) begin
                fb = s[6] ^ s[3];
                s = {s[5:0], fb};
                inb.push_back(raw[i] ^ fb);
            end else begin
                inb.push_back(raw[i]);
            end
        end
        expq = encode(inb, kind_of(rc));
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int nbytes = (v.nb + 7) / 8;
        int bidx = 0;
        int done_cnt = 0;
        int extra = 0;
        int mism = 0;
        bit xfer = 1'b0;
        bit fin = 1'b0;
        data.delete();
        got.delete();
        for (int j = 0; j < nbytes; j++) data.push_back(8'($urandom_range(0, 255)));
        if (v.byte0 >= 0 && nbytes > 0) data[0] = 8'(v.byte0);
        if (idx == 12) data = data_keep;
        build_model(v.rcode, v.scr, v.seed, v.nb);
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            @(negedge clock);
            if (cyc > 0) begin
                if (coded_out_strobe) got.push_back(coded_out);
                if (done) begin done_cnt++; fin = 1'b1; end
                if (xfer) bidx++;
            end
            if (cyc == 0) begin
                rate = {4'h0, v.rcode};
                do_scramble = v.scr;
                scramble_seed = v.seed;
                num_bits = 16'(v.nb);
                start = 1'b1;
            end else begin
                // parameters change and start re-pulses mid-frame; both must be ignored
                start = (cyc == 20);
                rate = 8'h0C;
                do_scramble = ~v.scr;
                scramble_seed = 7'h55;
                num_bits = 16'hFFFF;
            end
            out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in_valid = ($urandom_range(0, 3) != 0);
            byte_in = (bidx < data.size()) ? data[bidx] : 8'h00;
            xfer = byte_in_valid && byte_in_ready;
        end
        start = 1'b0;
        byte_in_valid = 1'b0;
        check($sformatf("f%0d_finished", idx), fin, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (coded_out_strobe) extra++;
            if (done) done_cnt++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) mism++;
        check($sformatf("f%0d_strobes", idx), got.size(), v.exp_strobes);
        check($sformatf("f%0d_model_len", idx), got.size(), expq.size());
        check($sformatf("f%0d_stream_mismatches", idx), mism, 0);
        check($sformatf("f%0d_done_pulses", idx), done_cnt, 1);
        check($sformatf("f%0d_strobes_after_done", idx), extra, 0);
        check($sformatf("f%0d_busy_after", idx), busy, 0);
        check($sformatf("f%0d_bytes_taken", idx), bidx, nbytes);
        if (idx == 5) begin data_keep = data; got_keep = got; end
    endtask

    initial begin
        logic [13:0] imp_ref = 14'b11011111001011;
        logic [13:0] imp_got;
        logic [15:0] svc_ref = 16'b0000111011110010;
        logic [31:0] svc_exp, svc_got;
        bq_t lit, lit_enc;
        int ones, mism, xfers, strobes, busy_seen;
        bit xf, reached;

        tbl[0]  = '{4'b1011, 1'b0, 7'h00, 1,   1'b0, 48,  1};
        tbl[1]  = '{4'b1011, 1'b0, 7'h00, 0,   1'b0, 48,  -1};
        tbl[2]  = '{4'b1011, 1'b1, 7'h7F, 0,   1'b0, 48,  -1};
        tbl[3]  = '{4'b1100, 1'b1, 7'h7F, 0,   1'b0, 288, -1};
        tbl[4]  = '{4'b1000, 1'b1, 7'h7F, 0,   1'b0, 288, -1};
        tbl[5]  = '{4'b1010, 1'b1, 7'h5D, 40,  1'b0, 192, -1};
        tbl[6]  = '{4'b1111, 1'b0, 7'h00, 30,  1'b0, 48,  -1};
        tbl[7]  = '{4'b1101, 1'b1, 7'h00, 100, 1'b0, 192, -1};
        tbl[8]  = '{4'b1110, 1'b1, 7'h2A, 13,  1'b1, 96,  -1};
        tbl[9]  = '{4'b1001, 1'b1, 7'h11, 77,  1'b1, 384, -1};
        tbl[10] = '{4'b1100, 1'b1, 7'h33, 200, 1'b1, 576, -1};
        tbl[11] = '{4'b1000, 1'b0, 7'h00, 186, 1'b1, 288, -1};
        tbl[12] = '{4'b1010, 1'b1, 7'h5D, 40,  1'b1, 192, -1};

        reset = 1'b1; enable = 1'b1; start = 1'b0; rate = 8'h0B; do_scramble = 1'b0;
        scramble_seed = 7'h00; num_bits = 16'd0; byte_in = 8'hA5; byte_in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_coded_out", coded_out, 0);
        check("reset_strobe", coded_out_strobe, 0);
        check("reset_byte_ready", byte_in_ready, 0);
        reset = 1'b0;
        byte_in_valid = 1'b0;
        @(negedge clock);

        for (int t = 0; t < 13; t++) begin
            run_frame(tbl[t], t);
            if (t == 0) begin
                imp_got = '0;
                for (int i = 0; i < 14 && i < got.size(); i++) imp_got[13 - i] = got[i];
                ones = 0;
                for (int i = 14; i < got.size(); i++) if (got[i]) ones++;
                check("impulse_first14", imp_got, imp_ref);
                check("impulse_trailing_ones", ones, 0);
            end
            if (t == 2) begin
                lit.delete();
                for (int i = 0; i < 16; i++) lit.push_back(svc_ref[15 - i]);
                lit_enc = encode(lit, 0);
                svc_exp = '0;
                svc_got = '0;
                for (int i = 0; i < 32; i++) svc_exp[31 - i] = lit_enc[i];
                for (int i = 0; i < 32 && i < got.size(); i++) svc_got[31 - i] = got[i];
                check("scrambled_service_coded", svc_got, svc_exp);
            end
            if (t == 12) begin
                mism = 0;
                for (int i = 0; i < got.size() && i < got_keep.size(); i++)
                    if (got[i] != got_keep[i]) mism++;
                check("backpressure_same_len", got.size(), got_keep.size());
                check("backpressure_same_bits", mism, 0);
            end
        end

        // Abort a frame while bytes are still being fetched.
        xfers = 0; xf = 1'b0; reached = 1'b0;
        for (int cyc = 0; cyc < 300 && !reached; cyc++) begin
            @(negedge clock);
            if (xf) xfers++;
            if (xfers >= 3) begin
                reached = 1'b1;
            end else begin
                rate = 8'h0B; do_scramble = 1'b0; scramble_seed = 7'h00;
                num_bits = 16'd64; start = (cyc == 0);
                byte_in = 8'($urandom_range(0, 255)); byte_in_valid = 1'b1; out_ready = 1'b1;
                xf = byte_in_valid && byte_in_ready;
            end
        end
        check("abort_reached_data", reached, 1);
        start = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_strobe", coded_out_strobe, 0);
        check("abort_byte_ready", byte_in_ready, 0);
        check("abort_done", done, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        strobes = 0; busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (coded_out_strobe) strobes++;
            if (busy) busy_seen++;
        end
        check("abort_no_strobes", strobes, 0);
        check("abort_stays_idle", busy_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_tx_encoder.md
OFDM_TX_ENCODER -- requirements
Module: ofdm_tx_encoder

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all logic on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all state.
REQ-003 SHALL have port enable, input, 1 bit: when low, all state holds and no handshake completes.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that launches a frame; ignored while busy=1.
REQ-005 SHALL have port rate, input, 8 bits: rate code sampled at start; [3:0] uses the codebase codes 1011=6M, 1111=9M, 1010=12M, 1110=18M, 1001=24M, 1101=36M, 1000=48M, 1100=54M.
REQ-006 SHALL have port do_scramble, input, 1 bit: sampled at start; 1 = DATA field (service bits plus scrambling), 0 = SIGNAL-type field.
REQ-007 SHALL have port scramble_seed, input, 7 bits: initial scrambler state, sampled at start.
REQ-008 SHALL have port num_bits, input, 16 bits: payload bit count, sampled at start.
REQ-009 SHALL have byte input ports byte_in (input, 8 bits), byte_in_valid (input, 1 bit) and byte_in_ready (output, 1 bit); a byte transfers when valid and ready are both 1.
REQ-010 SHALL have coded output ports coded_out (output, 1 bit), coded_out_strobe (output, 1 bit) and out_ready (input, 1 bit).
REQ-011 SHALL have status outputs busy (1 bit) and done (1 bit, one-cycle pulse).

Function
REQ-012 SHALL implement the states IDLE, SERVICE, DATA, TAIL, PAD and DONE.
REQ-013 In IDLE, start SHALL latch the parameters and go to SERVICE if do_scramble=1, to DATA if num_bits>0, otherwise to TAIL.
REQ-014 SERVICE SHALL feed 16 zero bits, then go to DATA, or to TAIL when num_bits=0.
REQ-015 DATA SHALL feed num_bits payload bits, LSB of each byte first.
REQ-016 A byte SHALL be fetched only when the 8-bit holding register is empty; the unused high bits of a final partial byte are discarded.
REQ-017 byte_in_ready SHALL be 1 only in DATA while the holding register is empty and bytes remain to be fetched.
REQ-018 TAIL SHALL feed 6 zero bits that bypass the scrambler.
REQ-019 PAD SHALL feed zero bits, scrambled when do_scramble=1, until the per-symbol input-bit counter wraps.
REQ-020 The per-symbol counter SHALL count every bit fed in all states and wrap at N_DBPS: 24, 36, 48, 72, 96, 144, 192 or 216 for 6M through 54M.
REQ-021 When the counter wraps at the end of TAIL, PAD SHALL be skipped.
REQ-022 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-023 The scrambler SHALL compute fb = s[6]^s[3], output bit ^ fb, and update s <= {s[5:0], fb} for each scrambled bit.
REQ-024 A scramble_seed of 0 SHALL be replaced by 7'h7F.
REQ-025 When do_scramble=0, the scrambler SHALL pass bits through unchanged.
REQ-026 The convolutional encoder SHALL hold history d[5:0], with d[0] the most recent bit, cleared at start.
REQ-027 The encoder SHALL compute A = b^d[1]^d[2]^d[4]^d[5] (generator 133 octal) and B = b^d[0]^d[1]^d[2]^d[5] (generator 171 octal).
REQ-028 The encoder SHALL shift d <= {d[4:0], b} for each input bit.
REQ-029 Puncturing: rate 1/2 (6/12/24M) SHALL emit A,B.
REQ-030 Puncturing: rate 2/3 (48M) SHALL emit A0,B0,A1 per 2 input bits.
REQ-031 Puncturing: rate 3/4 (9/18/36/54M) SHALL emit A0,B0,A1,B2 per 3 input bits.
REQ-032 The puncture phase SHALL reset at start.
REQ-033 Coded bits SHALL be emitted one per cycle in which out_ready=1 and a bit is pending, with coded_out_strobe=1 that cycle.
REQ-034 The next input bit SHALL be consumed only after all kept bits of the current pair have been emitted.
REQ-035 Latency from an accepted input bit to its first coded bit SHALL be at most 2 cycles when out_ready=1.
REQ-036 With out_ready=0, coded_out and coded_out_strobe SHALL NOT advance and no input bit SHALL be consumed.
REQ-037 done SHALL assert only after the last coded bit has been strobed.

Reset
REQ-038 On reset, the block SHALL enter IDLE.
REQ-039 On reset, busy, done, coded_out, coded_out_strobe and byte_in_ready SHALL be 0.
REQ-040 On reset, the scrambler state, encoder history, counters and holding register SHALL be 0.
REQ-041 Reset during a frame SHALL abort the frame immediately and emit no further strobes.

Verification
REQ-042 Impulse test: 6M, do_scramble=0, num_bits=1, byte 0x01 -> first 14 coded bits are 11 01 11 11 00 10 11, followed by zeros; 48 strobes in total.
REQ-043 Zero-length SIGNAL test: 6M, do_scramble=0, num_bits=0 -> 48 zero coded bits, then one done pulse.
REQ-044 Scrambler test: 6M, do_scramble=1, seed 7'h7F, num_bits=0 -> the first 16 coded inputs are scrambled service bits 0000111011110010.
REQ-045 54M padding test: do_scramble=1, num_bits=0 -> 216 input bits, 288 coded strobes; the same setup at 48M -> 192 input bits, 288 strobes.
REQ-046 Backpressure test: out_ready toggled randomly and reset asserted mid-DATA -> coded stream identical to the out_ready=1 run; after reset, busy=0 and no further strobes.
